amx_core2: RTL and testbench
============================

# amx_core2

Parametrised successor to the first-generation nibble arithmetic core: a streaming multiply-accumulate (dot-product) engine. It accepts a vector of operand pairs one word per cycle on a narrow input bus and accumulates their products in a widened internal accumulator. It then emits a wrapped or saturated result on the output bus. It sits directly behind the TinyTapeout top wrapper, fed from `ui_in` and driving `uo_out`.

## Interface
- `IN_W`, default 4: operand width in bits; must be 2..8.
- `DEPTH`, default 4: operand pairs per vector; must be 2..16.
- `OUT_W`, default 8: result width on `data_out`.
- Derived `ACC_W = 2*IN_W + clog2(DEPTH)`: internal accumulator width, never overflows.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; clears the accumulator and begins a new vector.
- `sat` input 1: result mode; 1 = saturate to `OUT_W`, 0 = wrap (low `OUT_W` bits). Sampled on the `start` cycle only.
- `valid_in` input 1: `data_in` holds an operand word this cycle.
- `data_in` input `IN_W`: unsigned operand word; order a0, b0, a1, b1, …
- `data_out` output `OUT_W`: result; holds until the next result is produced.
- `done` output 1: one-cycle pulse when `data_out` updates.
- `busy` output 1: high in `LOAD_A`, `LOAD_B` and `RESULT`.

## Operation
- **States:** `IDLE`, `LOAD_A`, `LOAD_B`, `RESULT`. Registers: `a_reg` (`IN_W`), `acc` (`ACC_W`), `cnt` (`clog2(DEPTH)`), `sat_reg`, `data_out`, `done`.
- **`IDLE`:** on `start`, clear `acc` and `cnt`, latch `sat_reg <= sat`, and go to `LOAD_A`. `valid_in` is ignored in `IDLE`.
- **`LOAD_A`:** on `valid_in`, `a_reg <= data_in` and go to `LOAD_B`. Without `valid_in`, stay (bubbles allowed).
- **`LOAD_B`:** on `valid_in`, `acc <= acc + a_reg*data_in`, with the product at full `2*IN_W` width and zero-extended.
  - If `cnt == DEPTH-1`, go to `RESULT`.
  - Otherwise `cnt <= cnt+1` and go to `LOAD_A`.
- **`RESULT`:** for one cycle, `data_out <= sat_reg ? min(acc, 2^OUT_W-1) : acc[OUT_W-1:0]` and `done <= 1`, then go to `IDLE`.
  - If `ACC_W <= OUT_W`, `acc` is zero-extended and saturation never triggers.
- **Restart:** `start` in any non-`IDLE` state aborts the vector: `acc` and `cnt` clear, `sat` is relatched, the state goes to `LOAD_A`, and `data_out` is unchanged. Any `valid_in` in that same cycle is ignored.
- **`start` in `RESULT`:** the result still commits (`data_out`, `done`) and the new vector starts, with the state going to `LOAD_A`.
- **`done`:** high for exactly one cycle per completed vector; it is never asserted for an aborted vector.
- **Reset:** while `rst_n` is low, every register clears immediately: state = `IDLE`, `data_out = 0`, `done = 0`, `busy = 0`, `acc = 0`, `cnt = 0`. Reset mid-vector discards all progress.

## Timing
- Throughput is one operand word per cycle when `valid_in` is held high.
- Minimum vector time is `2*DEPTH` accepting cycles plus 1 `RESULT` cycle.
- Latency:
  - Edge N accepts the final b word and the state enters `RESULT`.
  - Edge N+1 updates `data_out` and raises `done`.
  - Edge N+2 lowers `done`.
- `busy` rises the cycle after the `start` edge and falls the cycle after `done` is raised, unless restarted.
- Reset assertion is asynchronous. Deassertion is synchronised externally; the block samples nothing on the first edge after release other than `start`.

## Test plan
- **Basic dot product** (defaults, `sat=0`): `start`, then stream 1,5,2,6,3,7,4,8 back-to-back. Require `data_out = 70` (0x46), `done` high for 1 cycle exactly 9 cycles after the first word, and `busy` low afterwards.
- **Saturation vs wrap:** all words 15; `acc = 900`. Require `sat=1` gives 255 and `sat=0` gives 132 (0x84). Also change `sat` mid-vector and require no effect.
- **Bubbles:** same vector as the basic test, with `valid_in` low on alternate cycles and on 3 consecutive cycles between a1 and b1. Require 70, with `done` at the correct time and no extra accumulation.
- **Abort:** assert `start` after 3 pairs of all-15s. Then stream the basic vector. Require a single `done`, `data_out = 70`, and `data_out` holding its previous value until then.
- **Reset mid-vector:** assert `rst_n` low during `LOAD_B`. Require `data_out`, `done` and `busy` at 0 immediately without a clock edge, and that a following full vector computes correctly.
- **Parameter sweep:** check `IN_W=3, DEPTH=8, OUT_W=10` and `IN_W=8, DEPTH=2, OUT_W=8` against a reference model on 1000 random vectors, in both modes, with random bubbles and random `start` aborts.

Source files
------------

// File: rtl/amx_core2.sv
// Streaming multiply-accumulate (dot-product) engine. Operands arrive as a0,b0,a1,b1,...
// The result is emitted either wrapped or saturated to OUT_W bits.
module amx_core2 #(
  parameter int IN_W  = 4,
  parameter int DEPTH = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sat,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  output logic [OUT_W-1:0] data_out,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam int ACC_W = 2*IN_W + CNT_W;
  localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_A = 2'd1;
  localparam logic [1:0] LOAD_B = 2'd2;
  localparam logic [1:0] RESULT = 2'd3;

  localparam logic [CMP_W-1:0] OUT_MAX = CMP_W'({OUT_W{1'b1}});

  logic [1:0]        state;
  logic [IN_W-1:0]   a_reg;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              sat_reg;
  logic [2*IN_W-1:0] product;
  logic [CMP_W-1:0]  acc_ext;
  logic [OUT_W-1:0]  result;

  // Comparing at the wider of ACC_W/OUT_W means saturation can never fire when acc fits.
  always_comb begin
    product = (2*IN_W)'(a_reg) * (2*IN_W)'(data_in);
    acc_ext = CMP_W'(acc);
    if (sat_reg && (acc_ext > OUT_MAX))
      result = OUT_MAX[OUT_W-1:0];
    else
      result = acc_ext[OUT_W-1:0];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      sat_reg  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD_A: begin
          if (!start && valid_in) begin
            a_reg <= data_in;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (!start && valid_in) begin
            acc <= acc + ACC_W'(product);
            if (cnt == CNT_W'(DEPTH-1)) begin
              state <= RESULT;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= LOAD_A;
            end
          end
        end
        RESULT: begin
          data_out <= result;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // start wins over everything above except a result commit already in flight
      if (start) begin
        acc     <= '0;
        cnt     <= '0;
        sat_reg <= sat;
        state   <= LOAD_A;
      end
    end
  end

endmodule

// File: tb/tb_amx_core2.sv
// Testbench for amx_core2: directed vector table and hand-written corner sequences on the default build,
// plus randomised sweeps on two other parameter sets checked against a dot-product model.
module tb_amx_core2;

  typedef struct packed {
    logic        s;
    logic [31:0] w;
    logic [31:0] gap;
    logic [7:0]  exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       sw_rst_n;
  logic       start;
  logic       sat;
  logic       valid_in;
  logic [3:0] data_in;
  logic [7:0] data_out;
  logic       done;
  logic       busy;

  int n_checks;
  int n_pass;
  int spur;

  amx_core2 #(.IN_W(4), .DEPTH(4), .OUT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sat      (sat),
    .valid_in (valid_in),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic startVector(input logic s, input logic v);
    start = 1'b1;
    sat = s;
    valid_in = v;
    data_in = 4'd15;
    @(negedge clk);
    start = 1'b0;
    valid_in = 1'b0;
    sat = ~s;
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic streamWord(input logic [3:0] w, input int gap);
    repeat (gap) begin
      valid_in = 1'b0;
      @(negedge clk);
      if (done) spur++;
    end
    valid_in = 1'b1;
    data_in = w;
    @(negedge clk);
    if (done) spur++;
    valid_in = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    spur = 0;
    startVector(v.s, 1'b0);
    for (int i = 0; i < 8; i++)
      streamWord(v.w[4*i +: 4], (i == 0) ? 0 : int'(v.gap));
    checkOutput("no_early_done", spur, 0);
  endtask

  task automatic waitDone(input logic [7:0] exp, input string tag);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 6);
    checkOutput({tag, "_latency"}, lat, 1);
    checkOutput({tag, "_data"}, data_out, exp);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, done, 0);
    checkOutput({tag, "_busy_low"}, busy, 0);
  endtask

  // Randomised sweeps on the alternative parameter sets, each with its own stimulus and reset.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int IW = (g == 0) ? 3 : 8;
    localparam int DP = (g == 0) ? 8 : 2;
    localparam int OW = (g == 0) ? 10 : 8;

    logic          st, sa, vi, dn, bz, fin;
    logic [IW-1:0] di;
    logic [OW-1:0] dout;

    amx_core2 #(.IN_W(IW), .DEPTH(DP), .OUT_W(OW)) dut_sw (
      .clk      (clk),
      .rst_n    (sw_rst_n),
      .start    (st),
      .sat      (sa),
      .valid_in (vi),
      .data_in  (di),
      .data_out (dout),
      .done     (dn),
      .busy     (bz)
    );

    initial begin
      int sum, a_v, nw, sp, lat, expv, omax;
      logic mode;
      fin = 1'b0;
      st = 1'b0; sa = 1'b0; vi = 1'b0; di = '0;
      omax = (1 << OW) - 1;
      @(posedge sw_rst_n);
      @(negedge clk);
      for (int v = 0; v < 1000; v++) begin
        mode = 1'($urandom_range(0, 1));
        st = 1'b1; sa = mode; vi = 1'($urandom_range(0, 1)); di = IW'($urandom);
        @(negedge clk);
        st = 1'b0; vi = 1'b0; sa = ~mode;
        nw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2*DP-1)) : 2*DP;
        sum = 0; a_v = 0; sp = 0;
        for (int i = 0; i < nw; i++) begin
          while ($urandom_range(0, 3) == 0) begin
            vi = 1'b0;
            @(negedge clk);
            if (dn) sp++;
          end
          vi = 1'b1;
          di = IW'($urandom);
          if (i % 2 == 0) a_v = int'(di);
          else sum += a_v * int'(di);
          @(negedge clk);
          if (dn) sp++;
          vi = 1'b0;
        end
        checkOutput("sweep_no_early_done", sp, 0);
        if (nw == 2*DP) begin
          expv = mode ? ((sum > omax) ? omax : sum) : (sum % (omax + 1));
          lat = 0;
          do begin
            @(negedge clk);
            lat++;
          end while (!dn && lat < 6);
          checkOutput("sweep_latency", lat, 1);
          checkOutput("sweep_data", 32'(dout), expv);
        end
      end
      fin = 1'b1;
    end
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{s: 1'b0, w: 32'h84736251, gap: 0, exp: 8'd70};
    tbl[1] = '{s: 1'b1, w: 32'h84736251, gap: 1, exp: 8'd70};
    tbl[2] = '{s: 1'b1, w: 32'hFFFFFFFF, gap: 0, exp: 8'd255};
    tbl[3] = '{s: 1'b0, w: 32'hFFFFFFFF, gap: 0, exp: 8'd132};
    tbl[4] = '{s: 1'b1, w: 32'h001F1FFF, gap: 0, exp: 8'd255};
    tbl[5] = '{s: 1'b0, w: 32'h001F1FFF, gap: 2, exp: 8'd255};
    tbl[6] = '{s: 1'b1, w: 32'h111F1FFF, gap: 0, exp: 8'd255};
    tbl[7] = '{s: 1'b0, w: 32'h111F1FFF, gap: 0, exp: 8'd0};
    tbl[8] = '{s: 1'b1, w: 32'h00000000, gap: 0, exp: 8'd0};
    tbl[9] = '{s: 1'b0, w: 32'h329021FF, gap: 0, exp: 8'd233};

    n_checks = 0; n_pass = 0; spur = 0;
    start = 1'b0; sat = 1'b0; valid_in = 1'b0; data_in = 4'd0;
    rst_n = 1'b1; sw_rst_n = 1'b1;
    #2;
    rst_n = 1'b0; sw_rst_n = 1'b0;
    #2;
    checkOutput("reset_data_out", data_out, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1; sw_rst_n = 1'b1;

    // valid_in without start must not leave IDLE
    valid_in = 1'b1; data_in = 4'd15;
    repeat (2) @(negedge clk);
    valid_in = 1'b0;
    checkOutput("idle_ignores_valid", busy, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i]);
      waitDone(tbl[i].exp, $sformatf("vec%0d", i));
    end

    // sat sampled on start only
    spur = 0;
    startVector(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) streamWord(4'd15, 0);
    sat = 1'b0;
    for (int i = 0; i < 4; i++) streamWord(4'd15, 0);
    waitDone(8'd255, "sat_mid_vector");

    // bubbles, with a 3-cycle gap between a1 and b1
    spur = 0;
    startVector(1'b0, 1'b0);
    streamWord(4'd1, 0); streamWord(4'd5, 1); streamWord(4'd2, 1); streamWord(4'd6, 3);
    streamWord(4'd3, 1); streamWord(4'd7, 1); streamWord(4'd4, 1); streamWord(4'd8, 1);
    checkOutput("bubble_no_early_done", spur, 0);
    waitDone(8'd70, "bubbles");

    // abort after three pairs of 15s; prior result must hold
    applyStimulus(tbl[3]);
    waitDone(8'd132, "pre_abort");
    spur = 0;
    startVector(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) streamWord(4'd15, 0);
    checkOutput("abort_hold", data_out, 132);
    startVector(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) streamWord(tbl[0].w[4*i +: 4], 0);
    checkOutput("abort_hold_late", data_out, 132);
    checkOutput("abort_single_done", spur, 0);
    waitDone(8'd70, "abort");

    // start while in RESULT: result commits and the next vector begins
    spur = 0;
    startVector(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) streamWord(tbl[0].w[4*i +: 4], 0);
    start = 1'b1; sat = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_result_done", done, 1);
    checkOutput("restart_result_data", data_out, 70);
    checkOutput("restart_result_busy", busy, 1);
    for (int i = 0; i < 8; i++) streamWord(4'd15, 0);
    waitDone(8'd132, "restart_result");

    // asynchronous reset while in LOAD_B
    startVector(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) streamWord(4'd15, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_data", data_out, 0);
    checkOutput("async_rst_done", done, 0);
    checkOutput("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(tbl[0]);
    waitDone(8'd70, "after_reset");

    begin
      int c;
      c = 0;
      while (!(g_sweep[0].fin && g_sweep[1].fin) && c < 90000) begin
        @(negedge clk);
        c++;
      end
      checkOutput("sweep_finished", 32'(g_sweep[0].fin && g_sweep[1].fin), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
